keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Code-entry front end for the lock FSM: scans a 4x4 matrix keypad, debounces presses and delivers one 4-bit key code per physical press.
- Sends codes over a valid/ready handshake to the lock controller, which consumes digits in its INPUT state.
- Owns all keypad timing, so the lock FSM only ever sees clean, single-shot key events.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven (dwell); legal range >= 3 to cover 2-FF sync latency.
- DEBOUNCE, 3: consecutive identical scan frames required to accept a press, and consecutive empty frames required to accept a release; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- col_drive  output  4  one-hot, active-high column drive to the keypad.
- row_sense  input  4  row returns; bit r high when a key in row r of the driven column is pressed; asynchronous to clk.
- key_valid  output  1  key_code holds an unconsumed key.
- key_code  output  4  key index = row*4 + col.
- key_ready  input  1  consumer accepts key_code when key_valid && key_ready.
- overrun  output  1  sticky flag: an accepted press was dropped because key_valid was still high.

Behaviour:
- Reset (asynchronous, immediate, also mid-scan): col_drive=4'b0001, column index 0, dwell counter 0, debounce counter 0, state IDLE, key_valid=0, key_code=0, overrun=0, sync flops 0.
- row_sense passes through a 2-FF synchronizer before any use.
- Scan:
  - Column c is driven for SCAN_DIV cycles, then c advances 0->1->2->3->0 (wraps).
  - Synced rows are sampled on the last dwell cycle of each column.
  - One frame = 4*SCAN_DIV cycles; the frame ends on the last dwell cycle of column 3.
- Frame classification at frame end, over all 16 samples:
  - exactly one bit set -> SINGLE(code);
  - none set -> NONE;
  - two or more set -> MULTI, treated like NONE for acceptance.
- Debounce FSM, evaluated once per frame end:
  - IDLE: SINGLE(k) -> cand=k, cnt=1; go DEBOUNCE, or emit directly if DEBOUNCE==1. Anything else stays in IDLE.
  - DEBOUNCE: SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE, emit and go PRESSED. SINGLE(other), NONE or MULTI -> IDLE, cnt=0.
  - PRESSED: NONE increments the release count; any non-NONE frame resets it to 0. At DEBOUNCE consecutive NONE frames -> IDLE. A held key never repeats.
- Emit:
  - If key_valid==0: key_code<=cand and key_valid<=1, visible the cycle after the frame end.
  - If key_valid==1: the new key is dropped, key_code is unchanged, and overrun<=1. overrun clears only on reset.
- Handshake:
  - key_code stays stable while key_valid is high.
  - On a cycle with key_valid && key_ready, key_valid goes to 0 next cycle.
  - key_ready is ignored while key_valid is 0.
  - If an accept and an emit fall in the same cycle, the emit wins: key_valid stays 1, key_code takes the new key, and overrun is not set.
- Counter widths: dwell counter clog2(SCAN_DIV) bits; debounce and release counters clog2(DEBOUNCE+1) bits; no counter wraps past its terminal value.

Test Plan (SCAN_DIV=4, DEBOUNCE=3, frame=16 cycles; keypad model drives row_sense from col_drive):
- Single press: hold row1/col2 from reset release with key_ready=1 -> key_valid pulses exactly once, key_code=4'd6, first asserted <= 64 cycles after press; no repeat while held for 20 frames.
- Bounce: row3/col3 toggled every frame for 5 frames, then held -> no emit during toggling; one emit of 4'd15 after 3 stable frames.
- Backpressure and overrun: key_ready=0; press and release key 0, then press key 5 -> key_valid=1 with key_code=0; overrun=1 after the key-5 acceptance frame; raising key_ready clears key_valid next cycle while overrun stays 1.
- Multi-key: row0/col0 and row0/col1 held together for 6 frames -> no emit; release col1 -> emit 4'd0 after 3 frames.
- Release debounce: press key 9, accept it, then release for 2 frames, re-press 1 frame, release -> no second emit until 3 consecutive NONE frames then a fresh 3-frame press.
- Async reset mid-DEBOUNCE (frame 2 of 3), asserted between clock edges -> outputs go immediately to reset values (col_drive=4'b0001, key_valid=0, overrun=0); after release the key needs a full 3 frames again.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, debounce, one key code per press.
// Keys leave on a valid/ready handshake; a press arriving while a key is pending is dropped.
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] col_drive,
    input  logic [3:0] row_sense,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       overrun
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEB,
        S_PRESSED
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    col_drive_q, col_drive_d;
    logic [15:0]   samp_q, samp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rel_q, rel_d;
    logic [3:0]    cand_q, cand_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          overrun_q, overrun_d;

    logic          dwell_last;
    logic          frame_end;
    logic [15:0]   frame_bits;
    logic [4:0]    hits;
    logic [3:0]    code;
    logic          single;
    logic          none;
    logic          emit;

    always_comb begin
        state_d     = state_q;
        sync1_d     = row_sense;
        sync2_d     = sync1_q;
        dwell_d     = dwell_q;
        col_d       = col_q;
        col_drive_d = col_drive_q;
        samp_d      = samp_q;
        cnt_d       = cnt_q;
        rel_d       = rel_q;
        cand_d      = cand_q;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        overrun_d   = overrun_q;
        emit        = 1'b0;

        dwell_last = (dwell_q == DWELL_LAST);
        frame_end  = dwell_last && (col_q == 2'd3);

        // Current column's rows merged into this frame's sample map
        frame_bits = samp_q;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col_q == 2'(c)) begin
                    frame_bits[r*4 + c] = sync2_q[r];
                end
            end
        end

        hits = 5'd0;
        code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_bits[i]) begin
                hits = hits + 5'd1;
                code = 4'(i);
            end
        end
        single = (hits == 5'd1);
        none   = (hits == 5'd0);

        if (dwell_last) begin
            dwell_d     = '0;
            col_d       = col_q + 2'd1;
            col_drive_d = {col_drive_q[2:0], col_drive_q[3]};
            samp_d      = frame_bits;
        end else begin
            dwell_d = dwell_q + DWELL_ONE;
        end

        if (frame_end) begin
            unique case (state_q)
                S_IDLE: begin
                    if (single) begin
                        cand_d = code;
                        cnt_d  = CNT_ONE;
                        if (CNT_LAST == CNT_ONE) begin
                            emit    = 1'b1;
                            rel_d   = '0;
                            state_d = S_PRESSED;
                        end else begin
                            state_d = S_DEB;
                        end
                    end
                end
                S_DEB: begin
                    if (single && code == cand_q) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == CNT_LAST) begin
                            emit    = 1'b1;
                            rel_d   = '0;
                            state_d = S_PRESSED;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    if (none) begin
                        if (rel_q + CNT_ONE == CNT_LAST) begin
                            rel_d   = '0;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            rel_d = rel_q + CNT_ONE;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    rel_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end

        if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
        // An accept in the same cycle frees the slot, so the new key takes it
        if (emit) begin
            if (!key_valid_q || key_ready) begin
                key_valid_d = 1'b1;
                key_code_d  = code;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            dwell_q     <= '0;
            col_q       <= '0;
            col_drive_q <= 4'b0001;
            samp_q      <= '0;
            cnt_q       <= '0;
            rel_q       <= '0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            col_drive_q <= col_drive_d;
            samp_q      <= samp_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            overrun_q   <= overrun_d;
        end
    end

    assign col_drive = col_drive_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model on col_drive/row_sense, key scoreboard.
// Key changes are kept frame-aligned after each reset release.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  col_drive;
    logic [3:0]  row_sense;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready = 1'b0;
    logic        overrun;

    logic [15:0] keys = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_del = 0;
    int          base;
    int          lat;
    logic [3:0]  exp_q[$];

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .col_drive(col_drive),
        .row_sense(row_sense),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_sense[r] = |(keys[r*4 +: 4] & col_drive);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && key_valid && key_ready) begin
            n_del++;
            if (exp_q.size() == 0)
                chk("spurious_key", 32'(exp_q.size()), 32'd1);
            else
                chk("key_code", 32'(key_code), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        tick(16 * n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
    endtask

    initial begin
        // single press, held 20 frames
        keys = 16'h0040;
        key_ready = 1'b1;
        reset = 1'b1;
        tick(3);
        chk("rst_col", 32'(col_drive), 32'h1);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_code", 32'(key_code), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        reset = 1'b0;
        base = n_del;
        exp_q.push_back(4'd6);
        lat = 0;
        while (!key_valid && lat < 64) begin
            tick(1);
            lat++;
        end
        chk("t1_latency", 32'(lat), 32'd48);
        frames(20);
        chk("t1_once", 32'(n_del - base), 32'd1);
        keys = '0;
        frames(4);

        // bounce then stable
        do_reset();
        base = n_del;
        for (int i = 0; i < 5; i++) begin
            keys = (i % 2 == 0) ? 16'h8000 : 16'h0000;
            frames(1);
        end
        chk("t2_bounce", 32'(n_del - base), 32'd0);
        exp_q.push_back(4'd15);
        frames(2);
        chk("t2_valid", 32'(key_valid), 32'd1);
        frames(1);
        chk("t2_del", 32'(n_del - base), 32'd1);
        keys = '0;

        // backpressure and overrun
        do_reset();
        key_ready = 1'b0;
        base = n_del;
        keys = 16'h0001;
        frames(3);
        chk("t3_valid", 32'(key_valid), 32'd1);
        chk("t3_code", 32'(key_code), 32'd0);
        exp_q.push_back(4'd0);
        keys = '0;
        frames(3);
        keys = 16'h0020;
        frames(2);
        chk("t3_ovr_pre", 32'(overrun), 32'd0);
        frames(1);
        chk("t3_ovr", 32'(overrun), 32'd1);
        chk("t3_code_kept", 32'(key_code), 32'd0);
        tick(3);
        key_ready = 1'b1;
        tick(1);
        chk("t3_clear", 32'(key_valid), 32'd0);
        chk("t3_sticky", 32'(overrun), 32'd1);
        tick(12);
        keys = '0;
        frames(1);
        chk("t3_del", 32'(n_del - base), 32'd1);

        // two keys in one frame
        do_reset();
        base = n_del;
        keys = 16'h0003;
        frames(6);
        chk("t4_multi", 32'(n_del - base), 32'd0);
        keys = 16'h0001;
        exp_q.push_back(4'd0);
        frames(3);
        chk("t4_valid", 32'(key_valid), 32'd1);
        frames(1);
        chk("t4_del", 32'(n_del - base), 32'd1);
        keys = '0;

        // release debounce
        do_reset();
        base = n_del;
        keys = 16'h0200;
        exp_q.push_back(4'd9);
        frames(3);
        chk("t5_v1", 32'(key_valid), 32'd1);
        keys = '0;
        frames(2);
        keys = 16'h0200;
        frames(1);
        keys = '0;
        frames(1);
        keys = 16'h0200;
        frames(3);
        chk("t5_held", 32'(n_del - base), 32'd1);
        keys = '0;
        frames(3);
        keys = 16'h0200;
        frames(2);
        chk("t5_wait", 32'(key_valid), 32'd0);
        exp_q.push_back(4'd9);
        frames(1);
        chk("t5_v2", 32'(key_valid), 32'd1);
        frames(1);
        chk("t5_del", 32'(n_del - base), 32'd2);
        keys = '0;

        // async reset mid-debounce
        do_reset();
        key_ready = 1'b0;
        base = n_del;
        keys = 16'h0004;
        frames(3);
        keys = '0;
        frames(3);
        keys = 16'h0080;
        frames(3);
        chk("t6_ovr", 32'(overrun), 32'd1);
        keys = '0;
        frames(3);
        keys = 16'h0080;
        frames(2);
        tick(5);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_col", 32'(col_drive), 32'h1);
        chk("t6_valid", 32'(key_valid), 32'd0);
        chk("t6_code", 32'(key_code), 32'd0);
        chk("t6_ovr_clr", 32'(overrun), 32'd0);
        tick(2);
        reset = 1'b0;
        key_ready = 1'b1;
        frames(2);
        chk("t6_restart", 32'(key_valid), 32'd0);
        exp_q.push_back(4'd7);
        frames(1);
        chk("t6_v", 32'(key_valid), 32'd1);
        frames(1);
        chk("t6_del", 32'(n_del - base), 32'd1);
        keys = '0;
        frames(1);

        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
